// File: rtl/inst_prefetch_queue.sv
// inst_prefetch_queue: instruction prefetch FIFO with branch redirect and a single outstanding memory read.
// Defining IPQ_FLUSH_COUNT_EN adds a saturating 16-bit redirect counter on flush_cnt.
module inst_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic [31:0]            flush_pc,
    output logic                   mem_req,
    output logic [31:0]            mem_addr,
    input  logic                   mem_ack,
    input  logic [31:0]            mem_rdata,
    output logic                   ir_valid,
    output logic [31:0]            ir_data,
    output logic [31:0]            ir_pc,
    input  logic                   ir_ready,
    output logic [$clog2(DEPTH):0] count,
    output logic [15:0]            flush_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DISCARD} state_t;
    state_t state, state_n;
    logic [31:0] fetch_pc, disc_addr;
    logic [AW-1:0] head, tail;
    logic [31:0] q_data [DEPTH];
    logic [31:0] q_pc [DEPTH];
    logic push, pop;
    logic [AW:0] count_n;
    assign ir_valid = count != '0;
    assign ir_data  = q_data[head];
    assign ir_pc    = q_pc[head];
    assign push     = state == FETCH && mem_ack && !flush;
    assign pop      = ir_valid && ir_ready && !flush;
    assign count_n  = flush ? '0 : count + (AW+1)'(push) - (AW+1)'(pop);
    always_comb begin
        state_n  = state;
        mem_req  = state == FETCH || state == DISCARD;
        mem_addr = state == DISCARD ? disc_addr : fetch_pc;
        case (state)
            IDLE:    state_n = FETCH;
            // a flush without ack leaves a read in flight whose data must be dropped
            FETCH:   state_n = flush && !mem_ack ? DISCARD : push && count_n == FULL ? HOLD : FETCH;
            HOLD:    state_n = count < FULL ? FETCH : HOLD;
            DISCARD: state_n = mem_ack ? FETCH : DISCARD;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            fetch_pc  <= RESET_PC;
            disc_addr <= RESET_PC;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
        end else begin
            state     <= state_n;
            fetch_pc  <= flush ? flush_pc & 32'hFFFF_FFFC : push ? fetch_pc + 32'd4 : fetch_pc;
            disc_addr <= state == FETCH && flush && !mem_ack ? fetch_pc : disc_addr;
            count     <= count_n;
            head      <= flush ? '0 : head + AW'(pop);
            tail      <= flush ? '0 : tail + AW'(push);
        end
    end
    always_ff @(posedge clk) begin
        if (push) begin
            q_data[tail] <= mem_rdata;
            q_pc[tail]   <= fetch_pc;
        end
    end
`ifdef IPQ_FLUSH_COUNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) flush_cnt <= '0;
        else if (flush && flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
    end
`else
    assign flush_cnt = '0;
`endif
endmodule

// File: doc/inst_prefetch_queue.md
INST_PREFETCH_QUEUE -- requirements
Module: inst_prefetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entries (power of 2, >=2).
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address.
REQ-003 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-004 SHALL have ports: rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports: flush  in  1  redirect strobe (taken branch or PC write).
REQ-006 SHALL have ports: flush_pc  in  32  redirect target.
REQ-007 SHALL have ports: mem_req  out  1  instruction memory read request.
REQ-008 SHALL have ports: mem_addr  out  32  word-aligned read address.
REQ-009 SHALL have ports: mem_ack  in  1  one-cycle read completion.
REQ-010 SHALL have ports: mem_rdata  in  32  read data, valid with mem_ack.
REQ-011 SHALL have ports: ir_valid  out  1  head entry present.
REQ-012 SHALL have ports: ir_data  out  32  head instruction word.
REQ-013 SHALL have ports: ir_pc  out  32  address of head word.
REQ-014 SHALL have ports: ir_ready  in  1  consumer takes head (IR load strobe).
REQ-015 SHALL have ports: count  out  $clog2(DEPTH)+1  occupied entries.
REQ-016 SHALL have ports: flush_cnt  out  16  redirect counter (see Configuration).

Function
REQ-017 SHALL implement FSM states IDLE, FETCH, HOLD, DISCARD.
REQ-018 IDLE SHALL go to FETCH on the first clock edge after reset release.
REQ-019 FETCH SHALL assert mem_req with mem_addr = fetch_pc held stable until mem_ack is sampled high.
REQ-020 SHALL allow at most one outstanding read; a new request starts only when count < DEPTH, otherwise state HOLD with mem_req low.
REQ-021 On mem_ack in FETCH, SHALL push {fetch_pc, mem_rdata} at tail, fetch_pc += 4 (wraps 32'hFFFF_FFFC -> 0), stay in FETCH if post-edge count < DEPTH, else HOLD.
REQ-022 HOLD SHALL return to FETCH on the edge after count drops below DEPTH.
REQ-023 ir_valid SHALL equal (count != 0); ir_data/ir_pc SHALL be the head entry combinationally from storage.
REQ-024 Pop SHALL occur on edge where ir_valid && ir_ready; ir_ready with ir_valid low SHALL be ignored.
REQ-025 Simultaneous push and pop SHALL leave count unchanged; head/tail pointers wrap modulo DEPTH.
REQ-026 Fetch-to-use latency: mem_ack at edge N into empty queue SHALL give ir_valid=1 after edge N.
REQ-027 flush SHALL, at the same edge, empty the queue (count=0, pointers equal) and load fetch_pc = {flush_pc[31:2],2'b00}; flush overrides same-cycle push and pop.
REQ-028 flush while request outstanding and mem_ack low SHALL enter DISCARD: mem_req/mem_addr keep old values until mem_ack, data dropped, then FETCH at new fetch_pc.
REQ-029 flush coinciding with mem_ack SHALL drop that data and go to FETCH at flush target next cycle.
REQ-030 flush during DISCARD SHALL update fetch_pc only; state stays DISCARD.

Reset
REQ-031 On rst low, immediately and asynchronously: mem_req=0, mem_addr=RESET_PC, fetch_pc=RESET_PC, count=0, pointers 0, ir_valid=0, flush_cnt=0, state IDLE.
REQ-032 Reset mid-request SHALL abandon the read; a later mem_ack from memory is ignored while in IDLE.

Configuration
REQ-033 Macro IPQ_FLUSH_COUNT_EN defined: flush_cnt SHALL increment by 1 on every edge with flush=1, saturating at 16'hFFFF.
REQ-034 Macro IPQ_FLUSH_COUNT_EN undefined: flush_cnt SHALL be constant 0 and no counter register exists.

Verification
REQ-035 Reset release, mem_ack 1 cycle after each req, ir_ready=0 -> reads at 0x0,0x4,0x8,0xC, then HOLD, mem_req=0, count=4.
REQ-036 Queue full, ir_ready pulsed 1 cycle -> head ir_pc 0x0 popped, count=3, next request addr 0x10 issued on following cycle.
REQ-037 Request to 0x8 outstanding, flush with flush_pc=0x103 -> DISCARD, req held at 0x8 until ack, data dropped, next req addr 0x100, count=0.
REQ-038 flush same cycle as mem_ack and ir_ready with count=2 -> count=0, ir_valid=0, next req addr = flush target.
REQ-039 RESET_PC=32'hFFFF_FFF8, acks enabled -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0; ir_pc matches each word.
REQ-040 Three flushes with IPQ_FLUSH_COUNT_EN defined -> flush_cnt=3; undefined -> flush_cnt=0; rst low mid-request -> mem_req=0 before next edge.
